// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM states, coin-type codes and
// default coin values (common with the coin-accept controller).
package change_dispenser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    ISSUE  = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam logic [1:0] COIN0 = 2'd0;
  localparam logic [1:0] COIN1 = 2'd1;
  localparam logic [1:0] COIN2 = 2'd2;
  localparam logic [1:0] COIN3 = 2'd3;

  localparam int DEF_BAL_W   = 8;
  localparam int DEF_VAL0    = 1;
  localparam int DEF_VAL1    = 2;
  localparam int DEF_VAL2    = 5;
  localparam int DEF_VAL3    = 10;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the payout request, hopper handshake and completion status.
// The dispenser connects through the slave modport; its driver through master.
interface change_dispenser_if #(
  parameter int BAL_W = 8
);
  logic             start;
  logic [BAL_W-1:0] bal_in;
  logic [3:0]       empty;
  logic             coin_ack;
  logic             coin_valid;
  logic [1:0]       coin_type;
  logic             busy;
  logic             done;
  logic             error;
  logic [BAL_W-1:0] rem_out;

  modport slave (
    input  start, bal_in, empty, coin_ack,
    output coin_valid, coin_type, busy, done, error, rem_out
  );

  modport master (
    output start, bal_in, empty, coin_ack,
    input  coin_valid, coin_type, busy, done, error, rem_out
  );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// Combinational greedy picker: the largest coin that fits in the remainder
// and whose hopper tube is not empty.
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
#(
  parameter int BAL_W = DEF_BAL_W,
  parameter int VAL0  = DEF_VAL0,
  parameter int VAL1  = DEF_VAL1,
  parameter int VAL2  = DEF_VAL2,
  parameter int VAL3  = DEF_VAL3
) (
  input  logic [BAL_W-1:0] rem_i,
  input  logic [3:0]       empty_i,
  output logic             found_o,
  output logic [1:0]       sel_o
);

  localparam logic [BAL_W-1:0] V0 = BAL_W'(VAL0);
  localparam logic [BAL_W-1:0] V1 = BAL_W'(VAL1);
  localparam logic [BAL_W-1:0] V2 = BAL_W'(VAL2);
  localparam logic [BAL_W-1:0] V3 = BAL_W'(VAL3);

  // Later tests override earlier ones, so the highest eligible index wins.
  always_comb begin
    found_o = 1'b0;
    sel_o   = COIN0;
    if (!empty_i[0] && (V0 <= rem_i)) begin
      found_o = 1'b1;
      sel_o   = COIN0;
    end
    if (!empty_i[1] && (V1 <= rem_i)) begin
      found_o = 1'b1;
      sel_o   = COIN1;
    end
    if (!empty_i[2] && (V2 <= rem_i)) begin
      found_o = 1'b1;
      sel_o   = COIN2;
    end
    if (!empty_i[3] && (V3 <= rem_i)) begin
      found_o = 1'b1;
      sel_o   = COIN3;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a captured balance as coins, one hopper handshake per coin,
// and reports any unpaid remainder when it finishes or times out.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int BAL_W   = DEF_BAL_W,
  parameter int VAL0    = DEF_VAL0,
  parameter int VAL1    = DEF_VAL1,
  parameter int VAL2    = DEF_VAL2,
  parameter int VAL3    = DEF_VAL3,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  localparam logic [BAL_W-1:0] V0 = BAL_W'(VAL0);
  localparam logic [BAL_W-1:0] V1 = BAL_W'(VAL1);
  localparam logic [BAL_W-1:0] V2 = BAL_W'(VAL2);
  localparam logic [BAL_W-1:0] V3 = BAL_W'(VAL3);

  state_e           state_q;
  logic [BAL_W-1:0] rem_q;
  logic [BAL_W-1:0] rem_d;
  logic [1:0]       sel_q;
  logic             err_q;
  logic [TMR_W-1:0] timer_q;
  logic             found;
  logic [1:0]       pick;

  change_dispenser_coin_select #(
    .BAL_W (BAL_W),
    .VAL0  (VAL0),
    .VAL1  (VAL1),
    .VAL2  (VAL2),
    .VAL3  (VAL3)
  ) u_select (
    .rem_i   (rem_q),
    .empty_i (bus.empty),
    .found_o (found),
    .sel_o   (pick)
  );

  always_comb begin
    rem_d = rem_q - V0;
    case (sel_q)
      COIN1:   rem_d = rem_q - V1;
      COIN2:   rem_d = rem_q - V2;
      COIN3:   rem_d = rem_q - V3;
      default: rem_d = rem_q - V0;
    endcase
  end

  // An ack on the last timer cycle is checked first, so the coin still counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= COIN0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rem_q   <= bus.bal_in;
            err_q   <= 1'b0;
            state_q <= (bus.bal_in == '0) ? FINISH : SELECT;
          end
        end
        SELECT: begin
          if (found) begin
            sel_q   <= pick;
            timer_q <= '0;
            state_q <= ISSUE;
          end else begin
            err_q   <= 1'b1;
            state_q <= FINISH;
          end
        end
        ISSUE: begin
          if (bus.coin_ack) begin
            rem_q   <= rem_d;
            state_q <= (rem_d == '0) ? FINISH : SELECT;
          end else if (timer_q == TMR_LAST) begin
            err_q   <= 1'b1;
            state_q <= FINISH;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status is only meaningful once a payout has completed, and holds in IDLE.
  assign bus.coin_valid = (state_q == ISSUE);
  assign bus.coin_type  = sel_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == FINISH);
  assign bus.error      = err_q && ((state_q == FINISH) || (state_q == IDLE));
  assign bus.rem_out    = ((state_q == FINISH) || (state_q == IDLE)) ? rem_q : '0;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: acts as the coin hopper and compares
// every payout against a greedy change-making reference model.
module tb_change_dispenser;

  localparam int TIMEOUT      = 255;
  localparam int CYCLE_BUDGET = 3000;
  localparam int NEVER_ACK    = -1;
  localparam int RANDOM_ACK   = -2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   coinVal [4] = '{1, 2, 5, 10};

  change_dispenser_if #(.BAL_W(8)) bus ();

  change_dispenser #(
    .BAL_W   (8),
    .VAL0    (1),
    .VAL1    (2),
    .VAL2    (5),
    .VAL3    (10),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pickDelay(input int mode);
    if (mode >= 0) return mode;
    return $urandom_range(0, 3);
  endfunction

  // One complete payout: start, serve the hopper handshakes, verify the result.
  task automatic applyStimulus(input logic [7:0] bal, input logic [3:0] emp,
                               input int mode, input bit startNoise);
    int  expList[$];
    int  modelRem;
    int  best;
    int  expAccepted;
    int  expErr;
    int  expRem;
    int  accepted = 0;
    int  waitCnt = 0;
    int  target;
    int  validCycles = 0;
    int  cyc = 0;
    bit  sawDone = 0;
    bit  ackNow;
    logic [7:0] holdRem;
    logic       holdErr;

    modelRem = bal;
    while (modelRem > 0) begin
      best = -1;
      for (int i = 3; i >= 0; i--) begin
        if (best < 0 && !emp[i] && coinVal[i] <= modelRem) best = i;
      end
      if (best < 0) break;
      expList.push_back(best);
      modelRem -= coinVal[best];
    end
    if (mode == NEVER_ACK && expList.size() > 0) begin
      expAccepted = 0;
      expErr      = 1;
      expRem      = bal;
    end else begin
      expAccepted = expList.size();
      expErr      = (modelRem != 0) ? 1 : 0;
      expRem      = modelRem;
    end

    bus.start    = 1'b1;
    bus.bal_in   = bal;
    bus.empty    = emp;
    bus.coin_ack = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busyAfterStart", bus.busy, 1);
    if (bal == 0) begin
      checkOutput("zeroDone", bus.done, 1);
    end else begin
      checkOutput("selectNoValid", bus.coin_valid, 0);
      @(posedge clk); #1;
      checkOutput("firstCoinLatency", bus.coin_valid, (expList.size() > 0) ? 1 : 0);
    end

    target = pickDelay(mode);
    while (!sawDone && cyc < CYCLE_BUDGET) begin
      if (bus.done) begin
        sawDone = 1;
      end else begin
        ackNow = 0;
        if (bus.coin_valid) begin
          validCycles++;
          checkOutput("coinType", bus.coin_type,
                      (accepted < expList.size()) ? expList[accepted] : 99);
          if (mode != NEVER_ACK && waitCnt >= target) ackNow = 1;
          else waitCnt++;
        end
        bus.coin_ack = ackNow;
        if (startNoise) begin
          bus.start  = 1'($urandom_range(0, 1));
          bus.bal_in = 8'($urandom);
        end
        @(posedge clk); #1;
        bus.coin_ack = 1'b0;
        if (ackNow) begin
          accepted++;
          waitCnt = 0;
          target  = pickDelay(mode);
        end
        cyc++;
      end
    end
    bus.start = 1'b0;

    if (!sawDone) checkOutput("doneWithinBudget", 0, 1);
    checkOutput("coinsPaid", accepted, expAccepted);
    checkOutput("errorFlag", bus.error, expErr);
    checkOutput("remOut", bus.rem_out, expRem);
    if (mode == NEVER_ACK && expList.size() > 0)
      checkOutput("timeoutCycles", validCycles, TIMEOUT);

    holdRem = bus.rem_out;
    holdErr = bus.error;
    @(posedge clk); #1;
    checkOutput("donePulse", bus.done, 0);
    checkOutput("idleNotBusy", bus.busy, 0);
    checkOutput("remHold", bus.rem_out, expRem);
    checkOutput("errHold", bus.error, expErr);
    if (holdRem !== bus.rem_out || holdErr !== bus.error)
      checkOutput("statusStable", 0, 1);
  endtask

  initial begin
    int pollCnt;
    bus.start    = 1'b0;
    bus.bal_in   = '0;
    bus.empty    = '0;
    bus.coin_ack = 1'b0;
    reset        = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstValid", bus.coin_valid, 0);
    checkOutput("rstType", bus.coin_type, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstError", bus.error, 0);
    checkOutput("rstRem", bus.rem_out, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(8'd18, 4'b0000, RANDOM_ACK, 1'b0);
    applyStimulus(8'd0,  4'b0000, RANDOM_ACK, 1'b0);
    applyStimulus(8'd20, 4'b1000, RANDOM_ACK, 1'b0);
    applyStimulus(8'd3,  4'b0001, 0,          1'b0);
    applyStimulus(8'd7,  4'b0000, NEVER_ACK,  1'b0);
    applyStimulus(8'd10, 4'b0000, TIMEOUT - 1, 1'b0);
    applyStimulus(8'd9,  4'b1111, RANDOM_ACK, 1'b0);
    applyStimulus(8'd255, 4'b0000, 0,         1'b1);

    // Asynchronous reset in the middle of a coin offer.
    bus.start  = 1'b1;
    bus.bal_in = 8'd18;
    bus.empty  = 4'b0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    pollCnt = 0;
    while (!bus.coin_valid && pollCnt < 10) begin
      @(posedge clk); #1;
      pollCnt++;
    end
    checkOutput("offerBeforeReset", bus.coin_valid, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstValid", bus.coin_valid, 0);
    checkOutput("asyncRstBusy", bus.busy, 0);
    checkOutput("asyncRstRem", bus.rem_out, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    applyStimulus(8'd13, 4'b0000, RANDOM_ACK, 1'b1);

    for (int t = 0; t < 30; t++) begin
      logic [7:0] bal;
      logic [3:0] emp;
      int         mode;
      bal  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 60));
      emp  = 4'($urandom_range(0, 15));
      mode = ($urandom_range(0, 7) == 0) ? NEVER_ACK : RANDOM_ACK;
      applyStimulus(bal, emp, mode, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
